// File: rtl/countdown_pkg.sv
// Types and constants shared by the countdown preset controller, counter and display blocks.
// BCD digits are 4 bits wide; the units digit always runs 0..9.
package countdown_pkg;

  typedef enum logic [2:0] {SET_H, SET_L, LOAD, RUN, PAUSE} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_L = 4'd9;

  // Using >= keeps an out-of-range digit from running on past max.
  function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a one-cycle press pulse.
// A new level is accepted after DB_LIMIT consecutive samples that differ from the current one.
module btn_debounce #(
  parameter int DB_LIMIT = 1_000_000,
  parameter int DB_CNT_W = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam logic [DB_CNT_W-1:0] CNT_TOP = DB_CNT_W'(DB_LIMIT - 1);

  logic                sync_a;
  logic                sync_b;
  logic                level;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      pulse  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TOP) begin
        level <= sync_b;
        cnt   <= '0;
        // Only the press edge is reported; releases are accepted silently.
        pulse <= sync_b;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_preset_ctrl.sv
// Operator front end of the countdown: debounced buttons edit a BCD preset and drive the
// counter's load/run controls; the counter's done flag returns the FSM to editing.
//
//   state | meaning
//   SET_H | editing tens digit
//   SET_L | editing units digit
//   LOAD  | one-cycle load pulse to the counter
//   RUN   | counter enabled
//   PAUSE | counter held, resume or abort
module countdown_preset_ctrl
  import countdown_pkg::*;
#(
  parameter int   DB_LIMIT  = 1_000_000,
  parameter int   DB_CNT_W  = 20,
  parameter bcd_t MAX_H     = 4'd5,
  parameter bcd_t DEFAULT_H = 4'd5,
  parameter bcd_t DEFAULT_L = 4'd9
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_mode,
  input  logic btn_inc,
  input  logic btn_start,
  input  logic done,
  output bcd_t preset_h,
  output bcd_t preset_l,
  output logic load,
  output logic run,
  output logic edit_h,
  output logic edit_l
);

  logic   mode_p;
  logic   inc_p;
  logic   start_p;
  logic   done_q;
  logic   done_rise;
  logic   preset_zero;
  state_t state;
  state_t state_nx;
  bcd_t   h_nx;
  bcd_t   l_nx;

  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_mode (
    .clock(clock), .reset(reset), .raw(btn_mode), .pulse(mode_p)
  );

  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_inc (
    .clock(clock), .reset(reset), .raw(btn_inc), .pulse(inc_p)
  );

  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_start (
    .clock(clock), .reset(reset), .raw(btn_start), .pulse(start_p)
  );

  // done may be a level; only its first high cycle counts as an event.
  always_ff @(posedge clock) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done;
  end

  assign done_rise   = done & ~done_q;
  assign preset_zero = (preset_h == 4'd0) && (preset_l == 4'd0);

  always_comb begin
    state_nx = state;
    h_nx     = preset_h;
    l_nx     = preset_l;
    case (state)
      SET_H: begin
        if (start_p) begin
          if (!preset_zero) state_nx = LOAD;
        end else if (mode_p) begin
          state_nx = SET_L;
        end else if (inc_p) begin
          h_nx = bcd_inc(preset_h, MAX_H);
        end
      end
      SET_L: begin
        if (start_p) begin
          if (!preset_zero) state_nx = LOAD;
        end else if (mode_p) begin
          state_nx = SET_H;
        end else if (inc_p) begin
          l_nx = bcd_inc(preset_l, BCD_MAX_L);
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        if (done_rise)    state_nx = SET_H;
        else if (start_p) state_nx = PAUSE;
      end
      PAUSE: begin
        if (done_rise)    state_nx = SET_H;
        else if (start_p) state_nx = RUN;
        else if (mode_p)  state_nx = SET_H;
      end
      default: state_nx = SET_H;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SET_H;
      preset_h <= DEFAULT_H;
      preset_l <= DEFAULT_L;
      load     <= 1'b0;
      run      <= 1'b0;
      edit_h   <= 1'b1;
      edit_l   <= 1'b0;
    end else begin
      state    <= state_nx;
      preset_h <= h_nx;
      preset_l <= l_nx;
      load     <= (state_nx == LOAD);
      run      <= (state_nx == RUN);
      edit_h   <= (state_nx == SET_H);
      edit_l   <= (state_nx == SET_L);
    end
  end

endmodule

// File: tb/tb_countdown_preset_ctrl.sv
// Scoreboard bench: stimulus queues expected output snapshots (with due cycle), a monitor
// pops one for every change seen on the registered outputs.
module tb_countdown_preset_ctrl;
  import countdown_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  logic btn_start = 1'b0;
  logic done = 1'b0;
  bcd_t preset_h;
  bcd_t preset_l;
  logic load;
  logic run;
  logic edit_h;
  logic edit_l;

  countdown_preset_ctrl #(.DB_LIMIT(4), .DB_CNT_W(3)) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_start(btn_start), .done(done), .preset_h(preset_h), .preset_l(preset_l),
    .load(load), .run(run), .edit_h(edit_h), .edit_l(edit_l)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [11:0] v;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tp = 0;
  int   passed = 0;
  int   total = 0;

  localparam int B_MODE  = 0;
  localparam int B_INC   = 1;
  localparam int B_START = 2;

  always @(posedge clock) cyc <= cyc + 1;

  logic [11:0] obs;
  logic [11:0] prev = 'x;
  exp_t        e;

  always @(negedge clock) begin
    obs = {preset_h, preset_l, load, run, edit_h, edit_l};
    if (obs !== prev) begin
      prev = obs;
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_change: got %h at cycle %0d, required no change", obs, cyc);
      end else begin
        e = q.pop_front();
        if (obs === e.v && (e.cyc < 0 || e.cyc == cyc))
          passed++;
        else
          $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                   e.name, obs, cyc, e.v, e.cyc);
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] h, input logic [3:0] l,
                      input logic ld, input logic rn, input logic eh, input logic el,
                      input int c);
    exp_t x;
    x.name = nm;
    x.v    = {h, l, ld, rn, eh, el};
    x.cyc  = c;
    q.push_back(x);
  endtask

  task automatic hit(input int b);
    @(negedge clock);
    tp = cyc;
    case (b)
      B_MODE:  btn_mode  = 1'b1;
      B_INC:   btn_inc   = 1'b1;
      default: btn_start = 1'b1;
    endcase
  endtask

  task automatic let_go(input int hold);
    repeat (hold - 1) @(negedge clock);
    btn_mode  = 1'b0;
    btn_inc   = 1'b0;
    btn_start = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic pulse_done(input string nm, input logic [3:0] h, input logic [3:0] l,
                            input logic eh);
    @(negedge clock);
    tp = cyc;
    done = 1'b1;
    if (eh) push(nm, h, l, 0, 0, 1, 0, tp + 1);
    @(negedge clock);
    done = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clock);
    tp = cyc;
    reset = 1'b1;
    push(nm, 5, 9, 0, 0, 1, 0, tp + 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  initial begin
    // 1: reset values, then a glitch that must not register
    push("reset_state", 5, 9, 0, 0, 1, 0, -1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    btn_inc = 1'b1;
    @(negedge clock);
    btn_inc = 1'b0;
    repeat (12) @(negedge clock);

    // 2: tens wraps 5->0, then 0->1; change lands 7 edges after the raw rise
    hit(B_INC); push("inc_h_wrap", 0, 9, 0, 0, 1, 0, tp + 7); let_go(10);
    hit(B_INC); push("inc_h_0_1",  1, 9, 0, 0, 1, 0, tp + 7); let_go(10);

    // 3: units editing with wrap 9->0
    hit(B_MODE); push("mode_to_l",  1, 9, 0, 0, 0, 1, tp + 7); let_go(10);
    hit(B_INC);  push("inc_l_wrap", 1, 0, 0, 0, 0, 1, tp + 7); let_go(10);
    hit(B_INC);  push("inc_l_0_1",  1, 1, 0, 0, 0, 1, tp + 7); let_go(10);
    hit(B_INC);  push("inc_l_1_2",  1, 2, 0, 0, 0, 1, tp + 7); let_go(10);
    hit(B_MODE); push("mode_to_h",  1, 2, 0, 0, 1, 0, tp + 7); let_go(10);

    // 4: load/run, pause, resume without reload, done back to SET_H with preset kept
    hit(B_START);
    push("load_pulse", 1, 2, 1, 0, 0, 0, tp + 7);
    push("run_on",     1, 2, 0, 1, 0, 0, tp + 8);
    let_go(10);
    hit(B_START); push("pause",  1, 2, 0, 0, 0, 0, tp + 7); let_go(10);
    hit(B_START); push("resume", 1, 2, 0, 1, 0, 0, tp + 7); let_go(10);
    pulse_done("done_to_set_h", 1, 2, 1);

    // 5: preset 00 refuses start; abort from pause; done ignored while editing
    pulse_reset("reset_idle");
    hit(B_INC);  push("to_09",     0, 9, 0, 0, 1, 0, tp + 7); let_go(10);
    hit(B_MODE); push("to_09_l",   0, 9, 0, 0, 0, 1, tp + 7); let_go(10);
    hit(B_INC);  push("to_00",     0, 0, 0, 0, 0, 1, tp + 7); let_go(10);
    hit(B_START); let_go(10);
    hit(B_INC);  push("to_01",     0, 1, 0, 0, 0, 1, tp + 7); let_go(10);
    hit(B_START);
    push("load_01", 0, 1, 1, 0, 0, 0, tp + 7);
    push("run_01",  0, 1, 0, 1, 0, 0, tp + 8);
    let_go(10);
    hit(B_START); push("pause_01", 0, 1, 0, 0, 0, 0, tp + 7); let_go(10);
    hit(B_MODE);  push("abort",    0, 1, 0, 0, 1, 0, tp + 7); let_go(10);
    pulse_done("done_ignored", 0, 1, 0);

    // start and done in the same RUN cycle: done wins
    hit(B_START);
    push("load_b", 0, 1, 1, 0, 0, 0, tp + 7);
    push("run_b",  0, 1, 0, 1, 0, 0, tp + 8);
    let_go(10);
    hit(B_START);
    push("done_beats_start", 0, 1, 0, 0, 1, 0, tp + 7);
    repeat (6) @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    let_go(3);

    // 6: reset while running
    hit(B_START);
    push("load_c", 0, 1, 1, 0, 0, 0, tp + 7);
    push("run_c",  0, 1, 0, 1, 0, 0, tp + 8);
    let_go(10);
    pulse_reset("reset_mid_run");

    repeat (10) @(negedge clock);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL missing_events: got %0d expected changes never seen, required 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
